// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Merge new store data into an old word, one byte lane per enable bit.
  function automatic logic [WORD_W-1:0] be_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: byte-enabled synchronous write, combinational read
// that the responder samples on its commit edge. Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [WORD_W-1:0]        i_wdata,
  input  logic [BE_W-1:0]          i_be,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Byte-lane write of the addressed word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= be_merge(r_mem[i_idx], i_wdata, i_be);
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, LATENCY wait states, then a held
// response. Optional macro DMEM_RANGE_CHECK_EN flags addresses beyond DEPTH.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t              r_state, w_next;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_accept, w_commit, w_err, w_wr_en;
  logic                w_cur_we;
  logic [31:0]         w_cur_addr;
  logic [WORD_W-1:0]   w_cur_wdata, w_arr_rdata;
  logic [BE_W-1:0]     w_cur_be;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // With LATENCY=0 the commit edge is also the acceptance edge, so the
  // request fields come straight from the inputs while still in IDLE.
  assign w_cur_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_cur_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_cur_be    = (r_state == S_IDLE) ? req_be    : r_be;

`ifdef DMEM_RANGE_CHECK_EN
  assign w_err = (|w_cur_addr[1:0]) | (|(w_cur_addr >> (AW + 2)));
`else
  logic w_unused_addr;
  assign w_unused_addr = ^(w_cur_addr >> (AW + 2));
  assign w_err = |w_cur_addr[1:0];
`endif

  assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_wr_en  = w_commit && w_cur_we && !w_err;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .i_we   (w_wr_en),
    .i_idx  (w_cur_addr[AW+1:2]),
    .i_wdata(w_cur_wdata),
    .i_be   (w_cur_be),
    .o_rdata(w_arr_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (LATENCY > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
      r_cnt   <= (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
    end else if (r_state == S_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Response capture on the commit edge; held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_rdata <= (!w_cur_we && !w_err) ? w_arr_rdata : '0;
      r_err   <= w_err;
    end else if (r_state == S_RESP && rsp_ready) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
